gnn_layer_seq: RTL

GNN_LAYER_SEQ -- requirements
Module: gnn_layer_seq

---
 rtl/gnn_pkg.sv | 31 +++
 rtl/gnn_dot.sv | 32 +++
 rtl/gnn_layer_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/gnn_pkg.sv
// Shared state encoding and width/saturation helpers for the sequential GNN layer.
package gnn_pkg;

  typedef enum logic [2:0] {IDLE, AGG, L1, L2, OAGG, DONE} state_t;

  // Width of a lossless sum of n values each dw bits wide.
  function automatic int agg_w(input int dw, input int n);
    return dw + $clog2(n);
  endfunction

  function automatic int dot_w(input int aw, input int bw, input int len);
    return aw + bw + $clog2(len);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic longint sat_hi(input int ow);
    return (longint'(1) << (ow - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int ow);
    return -(longint'(1) << (ow - 1));
  endfunction

endpackage

// File: rtl/gnn_dot.sv
// Combinational signed dot product of LEN element pairs, accumulated at full precision.
module gnn_dot
  import gnn_pkg::*;
#(
  parameter int LEN = 4,
  parameter int AW  = 14,
  parameter int BW  = 5,
  parameter int RW  = 21
) (
  input  logic [LEN*AW-1:0]    a,
  input  logic [LEN*BW-1:0]    b,
  output logic signed [RW-1:0] result
);

  logic signed [AW-1:0]    av;
  logic signed [BW-1:0]    bv;
  logic signed [AW+BW-1:0] prod;

  always_comb begin
    av     = '0;
    bv     = '0;
    prod   = '0;
    result = '0;
    for (int i = 0; i < LEN; i++) begin
      av     = a[i*AW +: AW];
      bv     = b[i*BW +: BW];
      prod   = (AW+BW)'(av) * (AW+BW)'(bv);
      result = result + RW'(prod);
    end
  end

endmodule

// File: rtl/gnn_layer_seq.sv
// Sequential two-layer GNN: neighbour aggregation, dense+ReLU, dense, output aggregation, saturation.
module gnn_layer_seq
  import gnn_pkg::*;
#(
  parameter int N_NODES = 4,
  parameter int N_FEAT  = 4,
  parameter int N_HID   = 4,
  parameter int N_OUT   = 2,
  parameter int DW      = 5,
  parameter int OW      = 21,
  parameter int RELU_EN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_NODES*N_FEAT*DW-1:0]   x,
  input  logic [N_NODES*N_NODES-1:0]     adj,
  input  logic [N_FEAT*N_HID*DW-1:0]     w1,
  input  logic [N_HID*N_OUT*DW-1:0]      w2,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [N_NODES*N_OUT*OW-1:0]    out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           sat
);

  localparam int AW   = agg_w(DW, N_NODES);
  localparam int HW   = dot_w(AW, DW, N_FEAT);
  localparam int YW   = dot_w(HW, DW, N_HID);
  localparam int SW   = agg_w(YW, N_NODES);
  localparam int DLEN = max_i(N_FEAT, N_HID);
  localparam int RW   = dot_w(HW, DW, DLEN);
  localparam int IW   = $clog2(max_i(N_NODES, max_i(N_HID, N_OUT)) + 1);
  localparam int NIW  = idx_w(N_NODES);
  localparam int HIW  = idx_w(N_HID);
  localparam int OIW  = idx_w(N_OUT);

  state_t state, state_next;
  logic [IW-1:0]  row, col;
  logic [NIW-1:0] ri, cn;
  logic [HIW-1:0] ch;
  logic [OIW-1:0] co;
  logic last_inner, last_pair, row_done;

  logic signed [DW-1:0] x_r   [N_NODES][N_FEAT];
  logic                 adj_r [N_NODES][N_NODES];
  logic signed [DW-1:0] w1_r  [N_FEAT][N_HID];
  logic signed [DW-1:0] w2_r  [N_HID][N_OUT];
  logic signed [AW-1:0] a_r   [N_NODES][N_FEAT];
  logic signed [HW-1:0] h_r   [N_NODES][N_HID];
  logic signed [YW-1:0] y_r   [N_NODES][N_OUT];
  logic signed [SW-1:0] o_acc [N_NODES][N_OUT];

  logic [DLEN*HW-1:0]          dot_a;
  logic [DLEN*DW-1:0]          dot_b;
  logic signed [RW-1:0]        dot_res;
  logic signed [HW-1:0]        h_val;
  logic [N_NODES*N_OUT*OW-1:0] clamp_data;
  logic                        clamp_sat;
  longint                      v;

  assign ri        = row[NIW-1:0];
  assign cn        = col[NIW-1:0];
  assign ch        = col[HIW-1:0];
  assign co        = col[OIW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    last_inner = 1'b0;
    case (state)
      AGG, OAGG: last_inner = (col == IW'(N_NODES - 1));
      L1:        last_inner = (col == IW'(N_HID - 1));
      L2:        last_inner = (col == IW'(N_OUT - 1));
      default:   last_inner = 1'b0;
    endcase
    last_pair  = last_inner && (row == IW'(N_NODES - 1));
    row_done   = (row == IW'(N_NODES));
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = AGG;
      AGG:     if (last_pair) state_next = L1;
      L1:      if (last_pair) state_next = L2;
      L2:      if (last_pair) state_next = OAGG;
      // OAGG spends one extra cycle (row == N_NODES) clamping into out_data.
      OAGG:    if (row_done)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // L1 and L2 share one dot-product unit; unused lanes stay zero.
  always_comb begin
    dot_a = '0;
    dot_b = '0;
    if (state == L2) begin
      for (int k = 0; k < N_HID; k++) begin
        dot_a[k*HW +: HW] = h_r[ri][k];
        dot_b[k*DW +: DW] = w2_r[k][co];
      end
    end else begin
      for (int f = 0; f < N_FEAT; f++) begin
        dot_a[f*HW +: HW] = HW'(a_r[ri][f]);
        dot_b[f*DW +: DW] = w1_r[f][ch];
      end
    end
    h_val = dot_res[HW-1:0];
    if (RELU_EN != 0 && h_val < 0) h_val = '0;
  end

  gnn_dot #(.LEN(DLEN), .AW(HW), .BW(DW), .RW(RW)) u_dot (
    .a      (dot_a),
    .b      (dot_b),
    .result (dot_res)
  );

  always_comb begin
    clamp_data = '0;
    clamp_sat  = 1'b0;
    v          = 0;
    for (int i = 0; i < N_NODES; i++) begin
      for (int o = 0; o < N_OUT; o++) begin
        v = longint'(o_acc[i][o]);
        if (v > sat_hi(OW)) begin
          v = sat_hi(OW);
          clamp_sat = 1'b1;
        end else if (v < sat_lo(OW)) begin
          v = sat_lo(OW);
          clamp_sat = 1'b1;
        end
        clamp_data[(i*N_OUT+o)*OW +: OW] = v[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row      <= '0;
      col      <= '0;
      out_data <= '0;
      sat      <= 1'b0;
      for (int i = 0; i < N_NODES; i++) begin
        for (int f = 0; f < N_FEAT; f++)  begin x_r[i][f] <= '0; a_r[i][f] <= '0; end
        for (int j = 0; j < N_NODES; j++) adj_r[i][j] <= 1'b0;
        for (int k = 0; k < N_HID; k++)   h_r[i][k] <= '0;
        for (int o = 0; o < N_OUT; o++)   begin y_r[i][o] <= '0; o_acc[i][o] <= '0; end
      end
      for (int f = 0; f < N_FEAT; f++)
        for (int k = 0; k < N_HID; k++) w1_r[f][k] <= '0;
      for (int k = 0; k < N_HID; k++)
        for (int o = 0; o < N_OUT; o++) w2_r[k][o] <= '0;
    end else begin
      if (state_next != state) begin
        row <= '0;
        col <= '0;
      end else if (state != IDLE && state != DONE) begin
        if (last_inner) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      case (state)
        IDLE: if (in_valid) begin
          sat <= 1'b0;
          for (int i = 0; i < N_NODES; i++) begin
            for (int f = 0; f < N_FEAT; f++) begin
              x_r[i][f] <= x[(i*N_FEAT+f)*DW +: DW];
              a_r[i][f] <= '0;
            end
            for (int j = 0; j < N_NODES; j++) adj_r[i][j] <= adj[i*N_NODES+j];
            for (int o = 0; o < N_OUT; o++)   o_acc[i][o] <= '0;
          end
          for (int f = 0; f < N_FEAT; f++)
            for (int k = 0; k < N_HID; k++) w1_r[f][k] <= w1[(f*N_HID+k)*DW +: DW];
          for (int k = 0; k < N_HID; k++)
            for (int o = 0; o < N_OUT; o++) w2_r[k][o] <= w2[(k*N_OUT+o)*DW +: DW];
        end
        AGG: if (adj_r[ri][cn]) begin
          for (int f = 0; f < N_FEAT; f++) a_r[ri][f] <= a_r[ri][f] + AW'(x_r[cn][f]);
        end
        L1: h_r[ri][ch] <= h_val;
        L2: y_r[ri][co] <= dot_res[YW-1:0];
        OAGG: begin
          if (row_done) begin
            out_data <= clamp_data;
            sat      <= clamp_sat;
          end else if (adj_r[ri][cn]) begin
            for (int o = 0; o < N_OUT; o++) o_acc[ri][o] <= o_acc[ri][o] + SW'(y_r[cn][o]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
